// File: rtl/mod_addsub_pipe_if.sv
// mod_addsub_pipe_if: operand/result bundle for mod_addsub_pipe.
//
// Handshake: a beat moves from producer to consumer on a rising clock edge
// where valid && ready are both high. A producer holds its payload and valid
// steady until that edge. Ready may depend on the consumer's state but never
// on the valid it is paired with.
//
// Signals:
//   in_valid/in_ready  operand beat handshake (x, y, s are its payload)
//   s                  0 = add, 1 = subtract
//   x, y               operand residues, WIDTH bits
//   out_valid/out_ready result beat handshake (z, err are its payload)
//   z                  result residue, WIDTH bits
//   err                operand out of range (range-check builds only)
// Modports: master = operand source / result consumer, slave = the pipeline.
interface mod_addsub_pipe_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             s;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             err;

  modport master (
    output in_valid, s, x, y, out_ready,
    input  in_ready, out_valid, z, err
  );

  modport slave (
    input  in_valid, s, x, y, out_ready,
    output in_ready, out_valid, z, err
  );
endinterface

// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: three-stage pipelined modular adder/subtractor,
// z = (x +/- y) mod MODULUS on WIDTH-bit residues, one beat per cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (released synchronously upstream)
//   bus    mod_addsub_pipe_if.slave: in_valid/in_ready/s/x/y in,
//          out_valid/out_ready/z/err out
//
// Stages: S1 registers operands and the range flag, S2 registers the two
// candidate sums t0/t1 (WIDTH+2 bits, two's complement), S3 picks the
// in-range candidate. Each stage has its own valid bit and loads whenever its
// successor is empty or draining this cycle, so bubbles are kept in order.
//
// Build option: define MOD_ADDSUB_RANGE_CHECK_EN to flag operands >= MODULUS;
// a flagged beat emerges with err = 1 and z = 0. Without it err is constant 0.
module mod_addsub_pipe #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 13
) (
  input logic              clk,
  input logic              rst_n,
  mod_addsub_pipe_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 ||
      MODULUS > (64'd1 << WIDTH)) begin : g_bad_param
    $error("mod_addsub_pipe: WIDTH or MODULUS out of range");
  end

  localparam logic [WIDTH+1:0] M_EXT = MODULUS[WIDTH+1:0];

  // S1 state
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic             s1_q, s1_d;
  logic             e1_q, e1_d;
  // S2 state
  logic             v2_q, v2_d;
  logic [WIDTH+1:0] t0_q, t0_d;
  logic [WIDTH+1:0] t1_q, t1_d;
  logic             s2_q, s2_d;
  logic             e2_q, e2_d;
  // S3 state
  logic             v3_q, v3_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             err_q, err_d;

  logic             ld1, ld2, ld3;
  logic             range_flag;
  logic [WIDTH+1:0] x_ext, y_ext, sel;
  logic             sel_unused;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  localparam logic [WIDTH:0] M_CMP = MODULUS[WIDTH:0];
  assign range_flag = ({1'b0, bus.x} >= M_CMP) || ({1'b0, bus.y} >= M_CMP);
`else
  assign range_flag = 1'b0;
`endif

  // Load enables ripple back from the output; in_ready never looks at in_valid.
  assign ld3 = !v3_q || bus.out_ready;
  assign ld2 = !v2_q || ld3;
  assign ld1 = !v1_q || ld2;

  assign x_ext = {2'b00, x1_q};
  assign y_ext = {2'b00, y1_q};

  // Add: t1 is the reduced sum when non-negative. Subtract: t0 is the
  // difference when non-negative, otherwise t1 adds M back.
  assign sel = s2_q ? (t0_q[WIDTH+1] ? t1_q : t0_q)
                    : (t1_q[WIDTH+1] ? t0_q : t1_q);
  // Bit WIDTH of the selected candidate is always zero for in-range operands.
  assign sel_unused = ^sel[WIDTH+1:WIDTH];

  always_comb begin
    v1_d  = v1_q;
    x1_d  = x1_q;
    y1_d  = y1_q;
    s1_d  = s1_q;
    e1_d  = e1_q;
    v2_d  = v2_q;
    t0_d  = t0_q;
    t1_d  = t1_q;
    s2_d  = s2_q;
    e2_d  = e2_q;
    v3_d  = v3_q;
    z_d   = z_q;
    err_d = err_q;

    if (ld1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        x1_d = bus.x;
        y1_d = bus.y;
        s1_d = bus.s;
        e1_d = range_flag;
      end
    end

    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d = s1_q;
        e2_d = e1_q;
        if (s1_q) begin
          t0_d = x_ext - y_ext;
          t1_d = t0_d + M_EXT;
        end else begin
          t0_d = x_ext + y_ext;
          t1_d = t0_d - M_EXT;
        end
      end
    end

    // When S3 empties without a replacement, z/err keep their last value.
    if (ld3) begin
      v3_d = v2_q;
      if (v2_q) begin
        err_d = e2_q;
        z_d   = e2_q ? '0 : sel[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      x1_q  <= '0;
      y1_q  <= '0;
      s1_q  <= 1'b0;
      e1_q  <= 1'b0;
      v2_q  <= 1'b0;
      t0_q  <= '0;
      t1_q  <= '0;
      s2_q  <= 1'b0;
      e2_q  <= 1'b0;
      v3_q  <= 1'b0;
      z_q   <= '0;
      err_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      x1_q  <= x1_d;
      y1_q  <= y1_d;
      s1_q  <= s1_d;
      e1_q  <= e1_d;
      v2_q  <= v2_d;
      t0_q  <= t0_d;
      t1_q  <= t1_d;
      s2_q  <= s2_d;
      e2_q  <= e2_d;
      v3_q  <= v3_d;
      z_q   <= z_d;
      err_q <= err_d;
    end
  end

  assign bus.in_ready  = ld1;
  assign bus.out_valid = v3_q;
  assign bus.z         = z_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Bench for mod_addsub_pipe: one instance with M = 13 and one with M = 16,
// both WIDTH = 4. Accepted beats push a model result onto a per-instance
// queue; delivered results pop and compare in order.
`timescale 1ns/1ps
module tb_mod_addsub_pipe;
  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_addsub_pipe_if #(.WIDTH(W)) bus13 ();
  mod_addsub_pipe_if #(.WIDTH(W)) bus16 ();

  mod_addsub_pipe #(.WIDTH(W), .MODULUS(13)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus13)
  );

  mod_addsub_pipe #(.WIDTH(W), .MODULUS(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  // scoreboard: entries are {err, z}
  logic [W:0] exp_q[$];
  logic [W:0] exp16_q[$];
  int vec_count  = 0;
  int miss_count = 0;

  function automatic logic [W:0] model(input int a, input int b,
                                       input logic sub, input int m);
    int r;
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    if (a >= m || b >= m) return {1'b1, {W{1'b0}}};
`endif
    r = sub ? (a - b + m) % m : (a + b) % m;
    return {1'b0, r[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      miss_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor: sample at negedge, half a cycle away from the active edge
  always @(negedge clk) begin : monitor
    logic [W:0] e;
    if (rst_n) begin
      if (bus13.in_valid && bus13.in_ready)
        exp_q.push_back(model(int'(bus13.x), int'(bus13.y), bus13.s, 13));
      if (bus16.in_valid && bus16.in_ready)
        exp16_q.push_back(model(int'(bus16.x), int'(bus16.y), bus16.s, 16));
      if (bus13.out_valid && bus13.out_ready) begin
        if (exp_q.size() == 0) check("m13_unexpected_out", 8'd1, 8'd0);
        else begin
          e = exp_q.pop_front();
          check("m13_z", 8'(bus13.z), 8'(e[W-1:0]));
          check("m13_err", 8'(bus13.err), 8'(e[W]));
        end
      end
      if (bus16.out_valid && bus16.out_ready) begin
        if (exp16_q.size() == 0) check("m16_unexpected_out", 8'd1, 8'd0);
        else begin
          e = exp16_q.pop_front();
          check("m16_z", 8'(bus16.z), 8'(e[W-1:0]));
          check("m16_err", 8'(bus16.err), 8'(e[W]));
        end
      end
    end
  end

  // driver: present one beat, hold it until accepted, then drop in_valid
  task automatic send(input bit m16, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sub,
                      output int stalls);
    int n = 0;
    if (m16) begin
      bus16.x = a; bus16.y = b; bus16.s = sub; bus16.in_valid = 1'b1;
    end else begin
      bus13.x = a; bus13.y = b; bus13.s = sub; bus13.in_valid = 1'b1;
    end
    @(negedge clk);
    while (!(m16 ? bus16.in_ready : bus13.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 8'(n < 100), 8'd1);
    stalls = n;
    @(posedge clk); #1;
    if (m16) bus16.in_valid = 1'b0; else bus13.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit m16);
    int n = 0;
    while ((m16 ? exp16_q.size() : exp_q.size()) != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain_timeout", 8'((m16 ? exp16_q.size() : exp_q.size()) == 0), 8'd1);
  endtask

  // Send one beat into an empty M=13 pipe; out_valid rises after the third
  // rising edge counting the accepting one.
  task automatic latency_probe(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub);
    int st;
    send(1'b0, a, b, sub, st);
    check("latency_no_stall", 8'(st), 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("latency_out_valid", 8'(bus13.out_valid), 8'(i == 2));
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin : stimulus
    int st;
    bus13.in_valid = 1'b0; bus13.s = 1'b0; bus13.x = '0; bus13.y = '0;
    bus13.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.s = 1'b0; bus16.x = '0; bus16.y = '0;
    bus16.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 8'(bus13.out_valid), 8'd0);
    check("rst_z", 8'(bus13.z), 8'd0);
    check("rst_err", 8'(bus13.err), 8'd0);
    check("rst16_out_valid", 8'(bus16.out_valid), 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 8'(bus13.in_ready), 8'd1);
    check("post_rst_in_ready16", 8'(bus16.in_ready), 8'd1);

    // 9 + 7 mod 13 = 3, latency
    latency_probe(4'd9, 4'd7, 1'b0);
    wait_drain(1'b0);

    // back-to-back mixed add/subtract
    send(1'b0, 4'd3, 4'd8, 1'b1, st);  check("b2b_ready0", 8'(st), 8'd0);
    send(1'b0, 4'd12, 4'd0, 1'b0, st); check("b2b_ready1", 8'(st), 8'd0);
    send(1'b0, 4'd5, 4'd5, 1'b1, st);  check("b2b_ready2", 8'(st), 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_out_valid", 8'(bus13.out_valid), 8'(i < 3));
      @(posedge clk); #1;
    end
    wait_drain(1'b0);

    // backpressure: three beats fill the pipe, the fourth stalls
    bus13.out_ready = 1'b0;
    send(1'b0, 4'd1, 4'd2, 1'b0, st);  check("bp_ready0", 8'(st), 8'd0);
    send(1'b0, 4'd10, 4'd5, 1'b0, st); check("bp_ready1", 8'(st), 8'd0);
    send(1'b0, 4'd4, 4'd9, 1'b1, st);  check("bp_ready2", 8'(st), 8'd0);
    bus13.x = 4'd7; bus13.y = 4'd6; bus13.s = 1'b0; bus13.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 8'(bus13.in_ready), 8'd0);
      check("bp_out_valid_held", 8'(bus13.out_valid), 8'd1);
      check("bp_z_held", 8'(bus13.z), 8'd3);
      @(posedge clk); #1;
    end
    bus13.out_ready = 1'b1;
    send(1'b0, 4'd7, 4'd6, 1'b0, st);
    send(1'b0, 4'd11, 4'd12, 1'b1, st);
    wait_drain(1'b0);

    // reset with three beats in flight
    bus13.out_ready = 1'b0;
    send(1'b0, 4'd2, 4'd3, 1'b0, st);
    send(1'b0, 4'd6, 4'd6, 1'b0, st);
    send(1'b0, 4'd0, 4'd1, 1'b1, st);
    @(negedge clk);
    check("pre_rst_out_valid", 8'(bus13.out_valid), 8'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 8'(bus13.out_valid), 8'd0);
    check("midrst_z", 8'(bus13.z), 8'd0);
    check("midrst_err", 8'(bus13.err), 8'd0);
    exp_q.delete();
    exp16_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus13.out_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 8'(bus13.in_ready), 8'd1);
    latency_probe(4'd1, 4'd1, 1'b0);
    wait_drain(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_out", 8'(bus13.out_valid), 8'd0);
    end

    // full-range modulus 16
    send(1'b1, 4'd15, 4'd1, 1'b0, st);
    send(1'b1, 4'd0, 4'd1, 1'b1, st);
    send(1'b1, 4'd8, 4'd9, 1'b1, st);
    wait_drain(1'b1);

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    // out-of-range operand flagged, following beat clean
    send(1'b0, 4'd14, 4'd2, 1'b0, st);
    send(1'b0, 4'd2, 4'd2, 1'b0, st);
    wait_drain(1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
